lock_ctrl: RTL and testbench
============================

// Module: lock_ctrl
// PURPOSE
//  Keypad-to-blink sequencer for the digital lock; sits directly upstream of the LED blink stage.
//  Collects decimal key digits, compares them against a parameterised code, and issues one blink
//  request (GO pulse + ON/OFF/REPEAT pattern) per verdict. Waits for the blink stage's DONE, then
//  opens the lock, returns to entry, or enters a timed lockout after repeated failures.
// PARAMETERS
//  CLKFREQ    24'd12000000      CLK frequency in Hz; one decisecond = CLKFREQ/10 cycles
//  CODE_LEN   4                 digits per code, legal range 1..7
//  CODE       16'h1234          BCD code, 4*CODE_LEN bits; first-entered digit in the MS nibble
//  MAX_FAILS  3                 consecutive wrong codes that trigger lockout, legal range 1..7
//  LOCKOUT_DS 100               lockout duration in deciseconds, legal range >=1
//  RELOCK_DS  300               auto-relock time in OPEN, in deciseconds; 0 = never auto-relock
// PORTS
//  CLK          in   1  clock
//  RST          in   1  synchronous, active-high reset
//  KEY_VALID    in   1  one-cycle strobe: KEY_VAL is valid this cycle
//  KEY_VAL      in   4  0-9 = digit, 4'hF = clear/relock, 4'hA-4'hE ignored
//  BLINK_DONE   in   1  blink stage completion strobe
//  BLINK_GO     out  1  one-cycle blink request pulse
//  BLINK_ON     out  5  LED on-time per blink, deciseconds
//  BLINK_OFF    out  5  LED off-time per blink, deciseconds
//  BLINK_REPEAT out  3  number of blinks, always >=1
//  UNLOCKED     out  1  high while in state OPEN
//  LOCKED_OUT   out  1  high while in state LOCKOUT
//  DIGITS       out  3  digits entered so far in ENTRY, else 0
//  FAILS        out  3  consecutive wrong-code count
// BEHAVIOUR
//  Reset:
//   - state ENTRY; all outputs 0; entry register, timers and fail count cleared.
//   - RST mid-blink: BLINK_GO stays 0 and any later BLINK_DONE is ignored.
//  ENTRY:
//   - KEY_VALID with digit: shift into entry register, DIGITS+1.
//   - KEY_VALID with 4'hF: DIGITS=0.
//   - A-E ignored.
//   - The cycle after DIGITS reaches CODE_LEN: state CHECK.
//  CHECK (exactly 1 cycle):
//   - Next edge asserts BLINK_GO for 1 cycle and sets BLINK_* to the pattern below; DIGITS=0.
//   - match -> FAILS=0, OK pattern, state WAIT_OK.
//   - mismatch, FAILS+1<MAX_FAILS -> FAILS+1, FAIL pattern, state WAIT_FAIL.
//   - mismatch, FAILS+1==MAX_FAILS -> FAILS=MAX_FAILS, LOCK pattern, state WAIT_LOCK.
//  Patterns (ON/OFF/REPEAT):
//   - OK = 5/1/1
//   - FAIL = 2/2/3
//   - LOCK = 1/1/7
//   - BLINK_ON/OFF/REPEAT held stable from the GO cycle until BLINK_DONE is seen; 0 otherwise.
//  WAIT_OK/WAIT_FAIL/WAIT_LOCK:
//   - all keys ignored.
//   - BLINK_DONE -> OPEN / ENTRY / LOCKOUT respectively on the next edge.
//   - BLINK_DONE in any other state is ignored.
//   - no timeout; only RST exits a wait.
//  OPEN:
//   - UNLOCKED=1.
//   - KEY_VALID with 4'hF -> ENTRY.
//   - If RELOCK_DS!=0, RELOCK_DS deciseconds after entering OPEN -> ENTRY.
//   - A 4'hF key in the same cycle as the timeout -> ENTRY once, with no double action.
//  LOCKOUT:
//   - LOCKED_OUT=1; keys ignored.
//   - After LOCKOUT_DS*(CLKFREQ/10) cycles: FAILS=0, state ENTRY.
//  Timers:
//   - 32-bit cycle prescaler plus 16-bit decisecond counter.
//   - Both cleared on every state entry; no wrap-around within legal params.
//  KEY_VALID in the CHECK cycle, or coincident with a state transition, is dropped.
//  At most one BLINK_GO per verdict; BLINK_GO is never asserted outside the CHECK->WAIT edge.
// TESTING (sim CLKFREQ=100, so one decisecond = 10 cycles; RELOCK_DS=5, LOCKOUT_DS=3)
//  1 keys 1,2,3,4 -> CHECK; 1-cycle GO with 5/1/1; pulse DONE -> UNLOCKED=1 next cycle;
//    UNLOCKED=0 exactly 50 cycles after OPEN is entered.
//  2 keys 1,2,3,5 -> GO with 2/2/3, FAILS=1; DONE -> ENTRY, DIGITS=0; keys ignored before DONE.
//  3 three wrong codes -> third GO uses 1/1/7; DONE -> LOCKED_OUT=1 for 30 cycles;
//    keys are ignored during lockout; then FAILS=0 and state ENTRY.
//  4 keys 1,2,F,1,2,3,4 -> single OK verdict; key A mid-entry leaves DIGITS unchanged.
//  5 wrong code, then right code -> FAILS returns 0.
//    Key F while OPEN -> ENTRY.
//    Key F in the same cycle as the relock timeout -> single ENTRY transition.
//  6 RST asserted in WAIT_FAIL and in LOCKOUT -> all outputs 0, ENTRY;
//    a stray BLINK_DONE afterwards has no effect.

Source files
------------

// File: rtl/lock_ctrl.sv
// Keypad-to-blink sequencer for the digital lock: collects BCD digits, issues one blink
// request per verdict, then opens, returns to entry, or enforces a timed lockout.
module lock_ctrl #(
    parameter logic [23:0]           CLKFREQ    = 24'd12000000,
    parameter int                    CODE_LEN   = 4,
    parameter logic [4*CODE_LEN-1:0] CODE       = 16'h1234,
    parameter int                    MAX_FAILS  = 3,
    parameter int                    LOCKOUT_DS = 100,
    parameter int                    RELOCK_DS  = 300
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       KEY_VALID,
    input  logic [3:0] KEY_VAL,
    input  logic       BLINK_DONE,
    output logic       BLINK_GO,
    output logic [4:0] BLINK_ON,
    output logic [4:0] BLINK_OFF,
    output logic [2:0] BLINK_REPEAT,
    output logic       UNLOCKED,
    output logic       LOCKED_OUT,
    output logic [2:0] DIGITS,
    output logic [2:0] FAILS
);

    typedef logic [4*CODE_LEN-1:0] entry_t;

    typedef enum logic [2:0] {
        ST_ENTRY     = 3'd0,
        ST_CHECK     = 3'd1,
        ST_WAIT_OK   = 3'd2,
        ST_WAIT_FAIL = 3'd3,
        ST_WAIT_LOCK = 3'd4,
        ST_OPEN      = 3'd5,
        ST_LOCKOUT   = 3'd6
    } state_t;

    localparam logic [31:0] DS_CYC      = {8'd0, CLKFREQ} / 32'd10;
    localparam logic [31:0] DS_LAST     = DS_CYC - 32'd1;
    localparam logic [15:0] LOCK_LAST   = 16'(LOCKOUT_DS - 1);
    localparam logic [15:0] RELOCK_LAST = 16'(RELOCK_DS - 1);
    localparam logic        RELOCK_EN   = (RELOCK_DS != 0);
    localparam logic [2:0]  LEN_W       = 3'(CODE_LEN);
    localparam logic [2:0]  MAX_W       = 3'(MAX_FAILS);

    localparam logic [1:0] PAT_NONE = 2'd0;
    localparam logic [1:0] PAT_OK   = 2'd1;
    localparam logic [1:0] PAT_FAIL = 2'd2;
    localparam logic [1:0] PAT_LOCK = 2'd3;

    // Packed {ON, OFF, REPEAT} blink pattern for each verdict kind.
    function automatic logic [12:0] blink_pattern(input logic [1:0] kind);
        logic [12:0] p;
        case (kind)
            PAT_OK:   p = {5'd5, 5'd1, 3'd1};
            PAT_FAIL: p = {5'd2, 5'd2, 3'd3};
            PAT_LOCK: p = {5'd1, 5'd1, 3'd7};
            default:  p = 13'd0;
        endcase
        return p;
    endfunction

    state_t      state_r, state_nxt_s;
    entry_t      entry_r, entry_nxt_s;
    logic [2:0]  digits_r, digits_nxt_s;
    logic [2:0]  fails_r, fails_nxt_s;
    logic        go_r, go_nxt_s;
    logic [12:0] pat_r, pat_nxt_s;
    logic        unlocked_r, locked_r;
    logic [31:0] pre_r;
    logic [15:0] ds_r;
    logic        timed_s, ds_tick_s, relock_hit_s, lock_hit_s;

    assign timed_s      = (state_r == ST_OPEN) || (state_r == ST_LOCKOUT);
    assign ds_tick_s    = (pre_r == DS_LAST);
    assign relock_hit_s = RELOCK_EN && ds_tick_s && (ds_r == RELOCK_LAST);
    assign lock_hit_s   = ds_tick_s && (ds_r == LOCK_LAST);

    // State and registered-output update.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= ST_ENTRY;
            entry_r    <= '0;
            digits_r   <= 3'd0;
            fails_r    <= 3'd0;
            go_r       <= 1'b0;
            pat_r      <= 13'd0;
            unlocked_r <= 1'b0;
            locked_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            entry_r    <= entry_nxt_s;
            digits_r   <= digits_nxt_s;
            fails_r    <= fails_nxt_s;
            go_r       <= go_nxt_s;
            pat_r      <= pat_nxt_s;
            unlocked_r <= (state_nxt_s == ST_OPEN);
            locked_r   <= (state_nxt_s == ST_LOCKOUT);
        end
    end

    // Cycle prescaler and decisecond counter, restarted on every state change.
    always_ff @(posedge CLK) begin
        if (RST || (state_nxt_s != state_r) || !timed_s) begin
            pre_r <= 32'd0;
            ds_r  <= 16'd0;
        end else if (ds_tick_s) begin
            pre_r <= 32'd0;
            ds_r  <= ds_r + 16'd1;
        end else begin
            pre_r <= pre_r + 32'd1;
        end
    end

    // Next-state and next-output decode; keys are only acted on when no transition is pending.
    always_comb begin
        state_nxt_s  = state_r;
        entry_nxt_s  = entry_r;
        digits_nxt_s = digits_r;
        fails_nxt_s  = fails_r;
        go_nxt_s     = 1'b0;
        pat_nxt_s    = pat_r;
        case (state_r)
            ST_ENTRY: begin
                if (digits_r == LEN_W) begin
                    state_nxt_s = ST_CHECK;
                end else if (KEY_VALID && (KEY_VAL <= 4'd9)) begin
                    entry_nxt_s  = entry_t'({entry_r, KEY_VAL});
                    digits_nxt_s = digits_r + 3'd1;
                end else if (KEY_VALID && (KEY_VAL == 4'hF)) begin
                    entry_nxt_s  = '0;
                    digits_nxt_s = 3'd0;
                end else begin
                    digits_nxt_s = digits_r;
                end
            end
            ST_CHECK: begin
                go_nxt_s     = 1'b1;
                digits_nxt_s = 3'd0;
                if (entry_r == CODE) begin
                    fails_nxt_s = 3'd0;
                    pat_nxt_s   = blink_pattern(PAT_OK);
                    state_nxt_s = ST_WAIT_OK;
                end else if ((fails_r + 3'd1) < MAX_W) begin
                    fails_nxt_s = fails_r + 3'd1;
                    pat_nxt_s   = blink_pattern(PAT_FAIL);
                    state_nxt_s = ST_WAIT_FAIL;
                end else begin
                    fails_nxt_s = MAX_W;
                    pat_nxt_s   = blink_pattern(PAT_LOCK);
                    state_nxt_s = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_OK, ST_WAIT_FAIL, ST_WAIT_LOCK: begin
                if (BLINK_DONE) begin
                    pat_nxt_s = blink_pattern(PAT_NONE);
                    if (state_r == ST_WAIT_OK) begin
                        state_nxt_s = ST_OPEN;
                    end else if (state_r == ST_WAIT_FAIL) begin
                        state_nxt_s = ST_ENTRY;
                    end else begin
                        state_nxt_s = ST_LOCKOUT;
                    end
                end else begin
                    pat_nxt_s = pat_r;
                end
            end
            ST_OPEN: begin
                if ((KEY_VALID && (KEY_VAL == 4'hF)) || relock_hit_s) begin
                    state_nxt_s = ST_ENTRY;
                end else begin
                    state_nxt_s = ST_OPEN;
                end
            end
            ST_LOCKOUT: begin
                if (lock_hit_s) begin
                    fails_nxt_s = 3'd0;
                    state_nxt_s = ST_ENTRY;
                end else begin
                    state_nxt_s = ST_LOCKOUT;
                end
            end
            default: begin
                state_nxt_s  = ST_ENTRY;
                digits_nxt_s = 3'd0;
                pat_nxt_s    = 13'd0;
            end
        endcase
    end

    assign BLINK_GO     = go_r;
    assign BLINK_ON     = pat_r[12:8];
    assign BLINK_OFF    = pat_r[7:3];
    assign BLINK_REPEAT = pat_r[2:0];
    assign UNLOCKED     = unlocked_r;
    assign LOCKED_OUT   = locked_r;
    assign DIGITS       = digits_r;
    assign FAILS        = fails_r;

endmodule

// File: tb/tb_lock_ctrl.sv
// Randomized bench for lock_ctrl: a cycle-level reference model built from the lock's
// behavioural rules (digit queue, dwell-time counters) is checked against every DUT output.
module tb_lock_ctrl;

    localparam int RELOCK_CYC = 50;
    localparam int LOCK_CYC   = 30;
    localparam int M_ENTRY = 0, M_CHECK = 1, M_WOK = 2, M_WFAIL = 3, M_WLOCK = 4,
                   M_OPEN = 5, M_LOCKOUT = 6;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       KEY_VALID = 1'b0;
    logic [3:0] KEY_VAL = 4'd0;
    logic       BLINK_DONE = 1'b0;
    logic       BLINK_GO;
    logic [4:0] BLINK_ON, BLINK_OFF;
    logic [2:0] BLINK_REPEAT;
    logic       UNLOCKED, LOCKED_OUT;
    logic [2:0] DIGITS, FAILS;

    lock_ctrl #(
        .CLKFREQ(24'd100), .CODE_LEN(4), .CODE(16'h1234),
        .MAX_FAILS(3), .LOCKOUT_DS(3), .RELOCK_DS(5)
    ) dut (
        .CLK(CLK), .RST(RST), .KEY_VALID(KEY_VALID), .KEY_VAL(KEY_VAL),
        .BLINK_DONE(BLINK_DONE), .BLINK_GO(BLINK_GO), .BLINK_ON(BLINK_ON),
        .BLINK_OFF(BLINK_OFF), .BLINK_REPEAT(BLINK_REPEAT), .UNLOCKED(UNLOCKED),
        .LOCKED_OUT(LOCKED_OUT), .DIGITS(DIGITS), .FAILS(FAILS)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fails  = 0;

    int code_digits[4] = '{1, 2, 3, 4};
    int m_mode, m_fails, m_dwell, m_on, m_off, m_rep;
    bit m_go;
    int m_dig[$];

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_ENTRY; m_fails = 0; m_dwell = 0;
        m_on = 0; m_off = 0; m_rep = 0; m_go = 1'b0;
        m_dig.delete();
    endtask

    task automatic set_pat(input int on, input int off, input int rep);
        m_on = on; m_off = off; m_rep = rep;
    endtask

    task automatic model_step(input bit kv, input int kval, input bit done);
        int nm;
        bit match;
        nm = m_mode;
        m_go = 1'b0;
        case (m_mode)
            M_ENTRY: begin
                if (m_dig.size() == 4) nm = M_CHECK;
                else if (kv && kval <= 9) m_dig.push_back(kval);
                else if (kv && kval == 15) m_dig.delete();
            end
            M_CHECK: begin
                match = 1'b1;
                for (int i = 0; i < 4; i++) if (m_dig[i] != code_digits[i]) match = 1'b0;
                m_dig.delete();
                m_go = 1'b1;
                if (match) begin m_fails = 0; set_pat(5, 1, 1); nm = M_WOK; end
                else if (m_fails + 1 < 3) begin m_fails++; set_pat(2, 2, 3); nm = M_WFAIL; end
                else begin m_fails = 3; set_pat(1, 1, 7); nm = M_WLOCK; end
            end
            M_WOK, M_WFAIL, M_WLOCK: begin
                if (done) begin
                    set_pat(0, 0, 0);
                    nm = (m_mode == M_WOK) ? M_OPEN : (m_mode == M_WFAIL) ? M_ENTRY : M_LOCKOUT;
                end
            end
            M_OPEN: begin
                m_dwell++;
                if ((kv && kval == 15) || m_dwell == RELOCK_CYC) nm = M_ENTRY;
            end
            M_LOCKOUT: begin
                m_dwell++;
                if (m_dwell == LOCK_CYC) begin m_fails = 0; nm = M_ENTRY; end
            end
            default: nm = M_ENTRY;
        endcase
        if (nm != m_mode) m_dwell = 0;
        m_mode = nm;
    endtask

    task automatic compare_outputs();
        check_val("blink_go", BLINK_GO, m_go);
        check_val("blink_on", BLINK_ON, m_on);
        check_val("blink_off", BLINK_OFF, m_off);
        check_val("blink_repeat", BLINK_REPEAT, m_rep);
        check_val("unlocked", UNLOCKED, (m_mode == M_OPEN) ? 1 : 0);
        check_val("locked_out", LOCKED_OUT, (m_mode == M_LOCKOUT) ? 1 : 0);
        check_val("fails", FAILS, m_fails);
        if (m_mode != M_CHECK)
            check_val("digits", DIGITS, (m_mode == M_ENTRY) ? m_dig.size() : 0);
    endtask

    task automatic cycle(input bit rst, input bit kv, input int kval, input bit done);
        RST = rst; KEY_VALID = kv; KEY_VAL = 4'(kval); BLINK_DONE = done;
        @(posedge CLK);
        if (rst) model_reset();
        else model_step(kv, kval, done);
        @(negedge CLK);
        compare_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic press(input int k);
        cycle(1'b0, 1'b1, k, 1'b0);
        idle($urandom_range(0, 2));
    endtask

    task automatic enter_code(input int a, input int b, input int c, input int d);
        int ks[4];
        ks = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 3) == 0) press($urandom_range(10, 14));
            press(ks[i]);
        end
    endtask

    // Let the verdict reach a wait state, then acknowledge after a random delay.
    task automatic finish_blink();
        for (int i = 0; i < 10 && !(m_mode >= M_WOK && m_mode <= M_WLOCK); i++) idle(1);
        check_val("reached_wait", (m_mode >= M_WOK && m_mode <= M_WLOCK) ? 1 : 0, 1);
        idle($urandom_range(0, 4));
        cycle(1'b0, 1'b0, 0, 1'b1);
    endtask

    initial begin
        model_reset();
        cycle(1'b1, 1'b0, 0, 1'b0);
        cycle(1'b1, 1'b1, 1, 1'b1);
        check_val("reset_unlocked", UNLOCKED, 0);
        check_val("reset_digits", DIGITS, 0);

        // Correct code, open, then auto-relock after 50 cycles.
        enter_code(1, 2, 3, 4);
        finish_blink();
        check_val("open_after_done", UNLOCKED, 1);
        idle(RELOCK_CYC + 5);

        // Wrong code; keys during the blink wait are ignored.
        enter_code(1, 2, 3, 5);
        idle(2);
        press(1); press(2); press(3); press(4);
        finish_blink();

        // Two more wrong codes reach lockout; keys ignored while locked.
        enter_code(9, 9, 9, 9);
        finish_blink();
        enter_code(0, 0, 0, 0);
        finish_blink();
        check_val("lockout_entered", LOCKED_OUT, 1);
        for (int i = 0; i < 8; i++) press($urandom_range(0, 15));
        idle(LOCK_CYC);

        // Clear mid-entry, then correct code; F while open returns to entry.
        press(1); press(2); press(15);
        enter_code(1, 2, 3, 4);
        finish_blink();
        idle(5);
        press(15);

        // Wrong then right clears the fail count; F coincident with the relock timeout.
        enter_code(4, 3, 2, 1);
        finish_blink();
        enter_code(1, 2, 3, 4);
        finish_blink();
        for (int i = 0; i < RELOCK_CYC && m_mode == M_OPEN && m_dwell < RELOCK_CYC - 1; i++) idle(1);
        cycle(1'b0, 1'b1, 15, 1'b0);
        check_val("relock_coincident_f", UNLOCKED, 0);
        idle(3);

        // Reset while waiting on a fail blink and during lockout; stray DONE afterwards.
        enter_code(5, 5, 5, 5);
        idle(3);
        cycle(1'b1, 1'b0, 0, 1'b0);
        cycle(1'b0, 1'b0, 0, 1'b1);
        idle(2);
        for (int r = 0; r < 3; r++) begin
            enter_code(7, 7, 7, 7);
            finish_blink();
        end
        idle(5);
        cycle(1'b1, 1'b0, 0, 1'b0);
        cycle(1'b0, 1'b0, 0, 1'b1);
        idle(2);

        // Random traffic biased towards the correct code so every verdict kind occurs.
        for (int i = 0; i < 2500; i++) begin
            bit kv, dn, rs;
            int k;
            kv = ($urandom_range(0, 1) == 1);
            if (m_mode == M_ENTRY && m_dig.size() < 4 && $urandom_range(0, 2) != 0)
                k = code_digits[m_dig.size()];
            else
                k = $urandom_range(0, 15);
            dn = ($urandom_range(0, 5) == 0);
            rs = ($urandom_range(0, 299) == 0);
            cycle(rs, kv, k, dn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
